// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state encoding and default sizing for the FIFO push arbiter.
package fifo_arb_pkg;
    typedef enum logic {IDLE, LOCKED} state_t;
    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int TIMEOUT_DEF = 16;
endpackage

// File: rtl/fifo_push_arbiter_if.sv
// fifo_push_arbiter_if: requester beats in, single FIFO push port out.
// timeout_o exists only when FIFO_ARB_TIMEOUT_EN is defined.
interface fifo_push_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    logic [NUM_REQ-1:0] req_valid_i;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
    logic [NUM_REQ-1:0] req_last_i;
    logic [NUM_REQ-1:0] req_grant_o;
    logic push_valid_o;
    logic [DATA_WIDTH-1:0] push_data_o;
    logic push_grant_i;
    logic [$clog2(NUM_REQ)-1:0] owner_o;
    logic busy_o;
`ifdef FIFO_ARB_TIMEOUT_EN
    logic timeout_o;
    modport master (output req_valid_i, req_data_i, req_last_i, push_grant_i,
                    input req_grant_o, push_valid_o, push_data_o, owner_o, busy_o, timeout_o);
    modport slave (input req_valid_i, req_data_i, req_last_i, push_grant_i,
                   output req_grant_o, push_valid_o, push_data_o, owner_o, busy_o, timeout_o);
`else
    modport master (output req_valid_i, req_data_i, req_last_i, push_grant_i,
                    input req_grant_o, push_valid_o, push_data_o, owner_o, busy_o);
    modport slave (input req_valid_i, req_data_i, req_last_i, push_grant_i,
                   output req_grant_o, push_valid_o, push_data_o, owner_o, busy_o);
`endif
endinterface

// File: rtl/fifo_arb_rr_pick.sv
// fifo_arb_rr_pick: first set request at or above rr_ptr, wrapping around.
module fifo_arb_rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic any_valid
);
    localparam int IW = $clog2(NUM_REQ);
    logic [IW-1:0] idx;
    // Scan from the farthest offset down so the nearest requester overwrites last.
    always_comb begin
        winner = '0;
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = IW'((int'(rr_ptr) + k) % NUM_REQ);
            if (req[idx]) winner = idx;
        end
    end
    assign any_valid = |req;
endmodule

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: packet-locked round-robin arbiter feeding one FIFO push port.
// Define FIFO_ARB_TIMEOUT_EN to abort a lock whose owner stalls for TIMEOUT cycles.
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input logic clk,
    input logic reset,
    fifo_push_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    if (NUM_REQ < 2 || TIMEOUT < 2) begin : g_param_check
        $error("fifo_push_arbiter: NUM_REQ and TIMEOUT must be >= 2");
    end
    state_t state, state_nx;
    logic [IW-1:0] owner, owner_nx, rr_ptr, rr_nx, win, owner_inc;
    logic any, own_valid, locked, xfer, done, release_lock;
    assign locked = state == LOCKED;
    assign own_valid = bus.req_valid_i[owner];
    assign xfer = locked && own_valid && bus.push_grant_i;
    assign done = xfer && bus.req_last_i[owner];
    assign owner_inc = owner == IW'(NUM_REQ - 1) ? '0 : owner + 1'b1;
    fifo_arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req(bus.req_valid_i),
        .rr_ptr(rr_ptr),
        .winner(win),
        .any_valid(any)
    );
`ifdef FIFO_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0] cnt, cnt_nx;
    logic expire, timeout_q;
    assign expire = locked && !own_valid && cnt == CW'(TIMEOUT - 1);
    assign release_lock = done || expire;
    assign bus.timeout_o = timeout_q;
`else
    assign release_lock = done;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            owner <= '0;
            rr_ptr <= '0;
`ifdef FIFO_ARB_TIMEOUT_EN
            cnt <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            rr_ptr <= rr_nx;
`ifdef FIFO_ARB_TIMEOUT_EN
            cnt <= cnt_nx;
            timeout_q <= expire;
`endif
        end
    end
    // Arbitration happens only in IDLE, so back-to-back packets always see a bubble.
    always_comb begin
        state_nx = !locked ? (any ? LOCKED : IDLE) : (release_lock ? IDLE : LOCKED);
        owner_nx = !locked && any ? win : owner;
        rr_nx = locked && release_lock ? owner_inc : rr_ptr;
`ifdef FIFO_ARB_TIMEOUT_EN
        cnt_nx = (!locked || xfer) ? '0 : (own_valid ? cnt : cnt + 1'b1);
`endif
    end
    always_comb begin
        bus.busy_o = locked;
        bus.owner_o = owner;
        bus.push_valid_o = locked && own_valid;
        bus.push_data_o = locked ? DATA_WIDTH'(bus.req_data_i >> (int'(owner) * DATA_WIDTH)) : '0;
        bus.req_grant_o = xfer ? NUM_REQ'(1) << owner : '0;
    end
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb_fifo_push_arbiter: scoreboard bench; expected beats queued at drive time, popped on grants.
module tb_fifo_push_arbiter;
    localparam int N = 4;
    localparam int W = 8;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    fifo_push_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(W)) bus ();
    fifo_push_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .TIMEOUT(16)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );
    typedef struct {
        int owner;
        logic [W-1:0] data;
    } beat_t;
    beat_t sb[$];
    beat_t got_b;
    int checks = 0;
    int failures = 0;
    int grants = 0;
    // Every granted beat must match the oldest expected beat.
    always @(negedge clk) begin
        if (bus.req_grant_o !== '0) begin
            grants++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_grant got=%b exp=none", bus.req_grant_o);
            end else begin
                got_b = sb.pop_front();
                if (bus.req_grant_o !== 4'(1 << got_b.owner) || bus.push_data_o !== got_b.data || bus.push_valid_o !== 1'b1) begin
                    failures++;
                    $display("FAIL sb_beat got grant=%b data=%h valid=%b exp grant=%b data=%h valid=1",
                             bus.req_grant_o, bus.push_data_o, bus.push_valid_o, 4'(1 << got_b.owner), got_b.data);
                end
            end
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input logic g);
        bus.req_valid_i = v;
        bus.req_last_i = l;
        bus.push_grant_i = g;
        #1;
    endtask
    task automatic expect_beat(input int o, input logic [W-1:0] d);
        beat_t b;
        b.owner = o;
        b.data = d;
        sb.push_back(b);
    endtask
    task automatic do_reset();
        reset = 1'b1;
        bus.req_data_i = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        drive('0, '0, 1'b1);
        tick();
        tick();
        reset = 1'b0;
    endtask
    task automatic sb_drained(input string name);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_sb_left got=%0d exp=0", name, sb.size());
        end
    endtask
    task automatic test_reset();
        reset = 1'b1;
        bus.req_data_i = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        drive(4'b1111, 4'b1111, 1'b1);
        tick();
        tick();
        checks++;
        if ({bus.busy_o, bus.push_valid_o, bus.req_grant_o, bus.owner_o, bus.push_data_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b pv=%b grant=%b owner=%0d data=%h exp all 0",
                     bus.busy_o, bus.push_valid_o, bus.req_grant_o, bus.owner_o, bus.push_data_o);
        end
        drive('0, '0, 1'b1);
        reset = 1'b0;
    endtask
    task automatic test_alternate();
        do_reset();
        drive(4'b1010, 4'b1111, 1'b1);
        expect_beat(1, 8'hD1);
        expect_beat(3, 8'hD3);
        expect_beat(1, 8'hD1);
        tick();
        checks++;
        if (bus.owner_o !== 2'd1 || bus.busy_o !== 1'b1 || bus.req_grant_o !== 4'b0010) begin
            failures++;
            $display("FAIL alt_first got owner=%0d busy=%b grant=%b exp owner=1 busy=1 grant=0010",
                     bus.owner_o, bus.busy_o, bus.req_grant_o);
        end
        tick();
        checks++;
        if (bus.busy_o !== 1'b0 || bus.push_valid_o !== 1'b0 || bus.push_data_o !== 8'h00) begin
            failures++;
            $display("FAIL alt_bubble got busy=%b pv=%b data=%h exp 0 0 00", bus.busy_o, bus.push_valid_o, bus.push_data_o);
        end
        tick();
        checks++;
        if (bus.owner_o !== 2'd3 || bus.busy_o !== 1'b1) begin
            failures++;
            $display("FAIL alt_second got owner=%0d busy=%b exp owner=3 busy=1", bus.owner_o, bus.busy_o);
        end
        tick();
        tick();
        checks++;
        if (bus.owner_o !== 2'd1 || bus.busy_o !== 1'b1) begin
            failures++;
            $display("FAIL alt_third got owner=%0d busy=%b exp owner=1 busy=1", bus.owner_o, bus.busy_o);
        end
        tick();
        drive('0, '0, 1'b1);
        sb_drained("alt");
    endtask
    task automatic test_stall();
        int g0;
        do_reset();
        g0 = grants;
        bus.req_data_i[23:16] = 8'h20;
        drive(4'b0100, 4'b0000, 1'b1);
        expect_beat(2, 8'h20);
        tick();
        checks++;
        if (bus.owner_o !== 2'd2 || bus.busy_o !== 1'b1) begin
            failures++;
            $display("FAIL stall_lock got owner=%0d busy=%b exp owner=2 busy=1", bus.owner_o, bus.busy_o);
        end
        tick();
        bus.req_data_i[23:16] = 8'h21;
        drive(4'b0100, 4'b0000, 1'b0);
        expect_beat(2, 8'h21);
        checks++;
        if (bus.req_grant_o !== 4'b0000 || bus.push_valid_o !== 1'b1 || bus.push_data_o !== 8'h21) begin
            failures++;
            $display("FAIL stall_backpressure got grant=%b pv=%b data=%h exp 0000 1 21",
                     bus.req_grant_o, bus.push_valid_o, bus.push_data_o);
        end
        tick();
        drive(4'b0100, 4'b0000, 1'b1);
        checks++;
        if (bus.push_data_o !== 8'h21 || bus.req_grant_o !== 4'b0100) begin
            failures++;
            $display("FAIL stall_held got data=%h grant=%b exp 21 0100", bus.push_data_o, bus.req_grant_o);
        end
        tick();
        bus.req_data_i[23:16] = 8'h22;
        drive(4'b0100, 4'b0100, 1'b1);
        expect_beat(2, 8'h22);
        tick();
        checks++;
        if (bus.busy_o !== 1'b0 || grants - g0 != 3) begin
            failures++;
            $display("FAIL stall_release got busy=%b grants=%0d exp busy=0 grants=3", bus.busy_o, grants - g0);
        end
        bus.req_data_i = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        drive(4'b1001, 4'b1111, 1'b1);
        expect_beat(3, 8'hD3);
        tick();
        checks++;
        if (bus.owner_o !== 2'd3) begin
            failures++;
            $display("FAIL stall_rrptr got owner=%0d exp owner=3", bus.owner_o);
        end
        tick();
        drive('0, '0, 1'b1);
        sb_drained("stall");
    endtask
    task automatic test_round_robin();
        int order[5] = '{0, 1, 2, 3, 0};
        do_reset();
        drive(4'b1111, 4'b1111, 1'b1);
        foreach (order[k]) expect_beat(order[k], 8'(8'hD0 + order[k]));
        foreach (order[k]) begin
            tick();
            checks++;
            if (bus.busy_o !== 1'b1 || int'(bus.owner_o) != order[k]) begin
                failures++;
                $display("FAIL rr_order%0d got owner=%0d busy=%b exp owner=%0d busy=1", k, bus.owner_o, bus.busy_o, order[k]);
            end
            tick();
            checks++;
            if (bus.busy_o !== 1'b0) begin
                failures++;
                $display("FAIL rr_bubble%0d got busy=%b exp busy=0", k, bus.busy_o);
            end
        end
        drive('0, '0, 1'b1);
        sb_drained("rr");
    endtask
    task automatic test_wrap();
        do_reset();
        drive(4'b1100, 4'b1111, 1'b1);
        expect_beat(2, 8'hD2);
        expect_beat(3, 8'hD3);
        tick();
        tick();
        tick();
        checks++;
        if (bus.owner_o !== 2'd3) begin
            failures++;
            $display("FAIL wrap_owner3 got owner=%0d exp owner=3", bus.owner_o);
        end
        tick();
        drive(4'b0101, 4'b1111, 1'b1);
        expect_beat(0, 8'hD0);
        tick();
        checks++;
        if (bus.owner_o !== 2'd0 || bus.busy_o !== 1'b1) begin
            failures++;
            $display("FAIL wrap_winner got owner=%0d busy=%b exp owner=0 busy=1", bus.owner_o, bus.busy_o);
        end
        tick();
        drive('0, '0, 1'b1);
        sb_drained("wrap");
    endtask
    task automatic test_hold();
        do_reset();
        drive(4'b0001, 4'b0000, 1'b1);
        expect_beat(0, 8'hD0);
        tick();
        tick();
        drive(4'b0010, 4'b0000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.busy_o !== 1'b1 || bus.push_valid_o !== 1'b0 || bus.req_grant_o !== 4'b0000 || bus.owner_o !== 2'd0) begin
                failures++;
                $display("FAIL hold_lock%0d got busy=%b pv=%b grant=%b owner=%0d exp 1 0 0000 0",
                         i, bus.busy_o, bus.push_valid_o, bus.req_grant_o, bus.owner_o);
            end
            tick();
        end
        drive(4'b0011, 4'b0011, 1'b1);
        expect_beat(0, 8'hD0);
        expect_beat(1, 8'hD1);
        tick();
        tick();
        checks++;
        if (bus.owner_o !== 2'd1 || bus.busy_o !== 1'b1) begin
            failures++;
            $display("FAIL hold_next got owner=%0d busy=%b exp owner=1 busy=1", bus.owner_o, bus.busy_o);
        end
        tick();
        drive('0, '0, 1'b1);
        sb_drained("hold");
    endtask
    task automatic test_reset_mid();
        do_reset();
        drive(4'b0100, 4'b0000, 1'b1);
        expect_beat(2, 8'hD2);
        tick();
        tick();
        reset = 1'b1;
        drive(4'b0100, 4'b0000, 1'b0);
        tick();
        checks++;
        if ({bus.busy_o, bus.push_valid_o, bus.req_grant_o, bus.owner_o, bus.push_data_o} !== '0) begin
            failures++;
            $display("FAIL rstmid_outputs got busy=%b pv=%b grant=%b owner=%0d data=%h exp all 0",
                     bus.busy_o, bus.push_valid_o, bus.req_grant_o, bus.owner_o, bus.push_data_o);
        end
        reset = 1'b0;
        drive(4'b0101, 4'b1111, 1'b1);
        expect_beat(0, 8'hD0);
        tick();
        checks++;
        if (bus.owner_o !== 2'd0 || bus.busy_o !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_winner got owner=%0d busy=%b exp owner=0 busy=1", bus.owner_o, bus.busy_o);
        end
        tick();
        drive('0, '0, 1'b1);
        sb_drained("rstmid");
    endtask
`ifdef FIFO_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        do_reset();
        drive(4'b0001, 4'b0000, 1'b1);
        expect_beat(0, 8'hD0);
        tick();
        tick();
        drive(4'b0010, 4'b0010, 1'b1);
        while (n < 40 && bus.timeout_o !== 1'b1) begin
            tick();
            n++;
        end
        checks++;
        if (n != 16 || bus.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL timeout_pulse got cycles=%0d busy=%b exp cycles=16 busy=0", n, bus.busy_o);
        end
        expect_beat(1, 8'hD1);
        tick();
        checks++;
        if (bus.timeout_o !== 1'b0 || bus.owner_o !== 2'd1) begin
            failures++;
            $display("FAIL timeout_next got timeout=%b owner=%0d exp timeout=0 owner=1", bus.timeout_o, bus.owner_o);
        end
        tick();
        drive('0, '0, 1'b1);
        sb_drained("timeout");
    endtask
`endif
    initial begin
        bus.req_valid_i = '0;
        bus.req_last_i = '0;
        bus.push_grant_i = 1'b0;
        bus.req_data_i = '0;
        test_reset();
        test_alternate();
        test_stall();
        test_round_robin();
        test_wrap();
        test_hold();
        test_reset_mid();
`ifdef FIFO_ARB_TIMEOUT_EN
        test_timeout();
`endif
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
